vend_ctrl: RTL
==============

# vend_ctrl

Transaction controller for the drink vending datapath. Accumulates half-dollar and one-dollar coin pulses across multiple cycles into a credit register and sequences the vend. Handles cancel and inactivity timeout, then pays out change or a refund one half-dollar per cycle. Sits between the coin acceptor and the dispense/change mechanisms.

## Interface
- PRICE, 5, drink price in half-dollar units (5 = $2.50); 1 ≤ PRICE ≤ MAX_CREDIT
- MAX_CREDIT, 15, credit ceiling in half-dollar units; ≤ 255
- TIMEOUT, 255, idle cycles in ACCUM before automatic refund; ≥ 1
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; overrides ena
- ena  in  1  clock enable; 0 = hold all state, pulses forced 0
- coin_half  in  1  one-cycle pulse, half-dollar inserted (+1)
- coin_one  in  1  one-cycle pulse, one dollar inserted (+2)
- cancel  in  1  level, customer cancel request
- dispense_ready  in  1  dispense mechanism can accept a vend
- dispense  out  1  one-cycle pulse, release one drink
- collect  out  1  one-cycle pulse, bank the PRICE coins; coincident with dispense
- change_half  out  1  one-cycle pulse per half-dollar returned
- coin_reject  out  1  one-cycle pulse, coin(s) this cycle not accepted
- credit  out  8  current credit, half-dollar units
- state  out  3  IDLE=0, ACCUM=1, VEND=2, CHANGE=3, REFUND=4
- busy  out  1  state ∉ {IDLE, ACCUM}

## Operation
- Coin sum per cycle: coin_half + 2·coin_one, range 0..3. Both coins in the same cycle are legal.
- Coins are accepted only in IDLE/ACCUM, and only if credit + sum ≤ MAX_CREDIT. Otherwise the whole cycle's coins are rejected: coin_reject=1, credit unchanged.
- IDLE: credit = 0. Accepted coin → ACCUM with credit = sum. cancel is ignored.
- ACCUM: credit += accepted sum. Exit priority, first match wins:
  - cancel → REFUND
  - timeout → REFUND
  - new credit ≥ PRICE → VEND
  - otherwise stay in ACCUM
- VEND: waits for dispense_ready; cancel is ignored (committed). When ready=1:
  - dispense and collect pulse
  - credit -= PRICE
  - go to CHANGE if the remainder > 0, else IDLE
- CHANGE / REFUND: each cycle, change_half=1 and credit -= 1. When credit reaches 0, go to IDLE.
- Timeout counter:
  - cleared on entry to ACCUM and on every accepted coin
  - increments each enabled ACCUM cycle with no accepted coin
  - timeout fires when the count reaches TIMEOUT
- ena=0: state, credit and counter hold; all pulse outputs 0; coins are ignored and not rejected (upstream must not pulse while ena=0).
- reset=1: next edge sets state=IDLE, credit=0, counter=0, and every output 0, from any state including mid-payout (remaining change is dropped).

## Timing
- All outputs registered. Reset value 0 on every output; state=IDLE.
- Coin at edge n → credit updated and state change visible after edge n; coin_reject is asserted after the same edge.
- PRICE reached at edge n → VEND after n. If dispense_ready=1 at edge n+1 → dispense/collect high for exactly one cycle after n+1, with credit and state updated on the same edge.
- Change of k units: change_half is high for k consecutive cycles; IDLE follows the k-th pulse edge.
- A coin together with cancel in ACCUM: the coin is added, then REFUND returns the full total.
- Credit never underflows: decrements occur only when credit > 0 (CHANGE/REFUND) or credit ≥ PRICE (VEND).

## Structure
- Package vend_pkg holds:
  - state enum (3-bit encodings above)
  - coin value constants HALF_UNITS=1, ONE_UNITS=2
  - credit width constant CREDIT_W=8
- Sub-module vend_timer: loadable idle-timeout counter with inputs clr, inc, ena and output expired; parameter TIMEOUT.
- Top holds the FSM, the credit register and the output registers.

## Test plan
- Five coin_half pulses, dispense_ready=1 → dispense and collect one pulse each, change_half 0 times, credit 0, state IDLE.
- coin_one ×3 (credit 6) → one dispense, then exactly 1 change_half pulse, credit 0, IDLE.
- coin_half+coin_one in the same cycle (credit 3), then cancel → REFUND, 3 consecutive change_half pulses, no dispense.
- One coin_one, then TIMEOUT idle cycles → REFUND with 2 change_half pulses. A coin at cycle TIMEOUT-1 restarts the count.
- Hold dispense_ready=0 in VEND and insert coin_half → coin_reject pulse, credit unchanged. cancel is ignored. Raising ready vends normally.
- reset asserted during CHANGE with credit 4 → after the next edge credit=0, state=IDLE, and no further change_half. ena=0 for 10 cycles mid-ACCUM → credit and timeout count frozen.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    // Controller state; the encodings are visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_VEND   = 3'd2,
        ST_CHANGE = 3'd3,
        ST_REFUND = 3'd4
    } vend_state_t;

    // Coin values in half-dollar units.
    localparam int HALF_UNITS = 1;
    localparam int ONE_UNITS  = 2;

    // Width of the credit register.
    localparam int CREDIT_W = 8;

    // Value of one cycle's coin pulses in half-dollar units (0..3).
    function automatic logic [1:0] coin_value(input logic half, input logic one);
        logic [1:0] v;
        v = 2'd0;
        if (half) v = v + 2'(HALF_UNITS);
        if (one)  v = v + 2'(ONE_UNITS);
        return v;
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Coin acceptor / dispense / change signals of the vending controller.
//
// Handshake: dispense_ready is a level from the dispense mechanism meaning it
// can take a vend this cycle; the controller answers with a single-cycle
// dispense (and collect) pulse only in a cycle after it sampled
// dispense_ready=1 while waiting in VEND. Coin pulses have no back-pressure:
// a coin that cannot be taken is answered with a coin_reject pulse.
interface vend_ctrl_if;
    import vend_pkg::*;

    logic                coin_half;
    logic                coin_one;
    logic                cancel;
    logic                dispense_ready;
    logic                dispense;
    logic                collect;
    logic                change_half;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          state;
    logic                busy;

    // Controller side.
    modport slave (
        input  coin_half, coin_one, cancel, dispense_ready,
        output dispense, collect, change_half, coin_reject, credit, state, busy
    );

    // Coin acceptor / mechanism side.
    modport master (
        output coin_half, coin_one, cancel, dispense_ready,
        input  dispense, collect, change_half, coin_reject, credit, state, busy
    );
endinterface

// File: rtl/vend_timer.sv
// Idle-timeout counter for the ACCUM state. expired is a look-ahead: it is
// high in the idle cycle whose edge brings the count to TIMEOUT, so the FSM
// leaves ACCUM on exactly that edge.
module vend_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment; saturate at TIMEOUT.
    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (ena) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc) begin
                if (cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
                expired = (cnt_q == LAST);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin accumulation, vend sequencing,
// cancel/timeout refund and one-half-dollar-per-cycle change payout.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    vend_ctrl_if.slave  bus
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic                collect_q, collect_d;
    logic                change_half_q, change_half_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [1:0]          coin_sum;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_any;
    logic                coin_acc;
    logic                tmr_inc;
    logic                tmr_expired;

    // Coin acceptance: only in IDLE/ACCUM and only if the ceiling holds.
    always_comb begin
        coin_sum   = coin_value(bus.coin_half, bus.coin_one);
        coin_any   = (coin_sum != 2'd0);
        credit_sum = {1'b0, credit_q} + {{(CREDIT_W - 1){1'b0}}, coin_sum};
        coin_acc   = ena && coin_any && (credit_sum <= MAX_C) &&
                     ((state_q == ST_IDLE) || (state_q == ST_ACCUM));
        tmr_inc    = (state_q == ST_ACCUM) && !coin_acc;
    end

    vend_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .ena     (ena),
        .clr     (coin_acc),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // Next state, next credit and next pulse outputs.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        dispense_d    = 1'b0;
        collect_d     = 1'b0;
        change_half_d = 1'b0;
        coin_reject_d = 1'b0;
        if (ena) begin
            coin_reject_d = coin_any && !coin_acc;
            case (state_q)
                ST_IDLE: begin
                    if (coin_acc) begin
                        state_d  = ST_ACCUM;
                        credit_d = credit_sum[CREDIT_W-1:0];
                    end
                end
                ST_ACCUM: begin
                    if (coin_acc) credit_d = credit_sum[CREDIT_W-1:0];
                    if (bus.cancel)              state_d = ST_REFUND;
                    else if (tmr_expired)        state_d = ST_REFUND;
                    else if (credit_d >= PRICE_C) state_d = ST_VEND;
                end
                ST_VEND: begin
                    // Committed: cancel is not looked at here.
                    if (bus.dispense_ready && (credit_q >= PRICE_C)) begin
                        dispense_d = 1'b1;
                        collect_d  = 1'b1;
                        credit_d   = credit_q - PRICE_C;
                        state_d    = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
                    end
                end
                ST_CHANGE, ST_REFUND: begin
                    if (credit_q != '0) begin
                        change_half_d = 1'b1;
                        credit_d      = credit_q - CREDIT_W'(1);
                        if (credit_q == CREDIT_W'(1)) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                end
            endcase
        end
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_ACCUM));
    end

    // State, credit and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            dispense_q    <= 1'b0;
            collect_q     <= 1'b0;
            change_half_q <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            collect_q     <= collect_d;
            change_half_q <= change_half_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.dispense    = dispense_q;
    assign bus.collect     = collect_q;
    assign bus.change_half = change_half_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.credit      = credit_q;
    assign bus.state       = state_q;
    assign bus.busy        = busy_q;
endmodule
